// File: rtl/tsp_stim_checker_if.sv
// ============================================================================
// Module      : tsp_stim_checker_if
// Description : Control, status and TSP-facing signal bundle of the stimulus
//               checker; master is the checker, slave is its environment.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface tsp_stim_checker_if #(
   parameter int DWIDTH      = 8,
   parameter int NUM_VECTORS = 16,
   parameter int CNT_W       = 16
);
   localparam int c_idx_w = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;

   logic                start_i;
   logic [DWIDTH-1:0]   seed_i;
   logic [DWIDTH-1:0]   res_i;
   logic [DWIDTH-1:0]   op1_o;
   logic [DWIDTH-1:0]   op2_o;
   logic                busy_o;
   logic                done_o;
   logic                pass_o;
   logic [CNT_W-1:0]    err_cnt_o;
   logic [c_idx_w-1:0]  first_err_idx_o;
   logic [DWIDTH-1:0]   first_err_exp_o;
   logic [DWIDTH-1:0]   first_err_got_o;

   modport master (
      input  start_i, seed_i, res_i,
      output op1_o, op2_o, busy_o, done_o, pass_o, err_cnt_o,
             first_err_idx_o, first_err_exp_o, first_err_got_o
   );

   modport slave (
      output start_i, seed_i, res_i,
      input  op1_o, op2_o, busy_o, done_o, pass_o, err_cnt_o,
             first_err_idx_o, first_err_exp_o, first_err_got_o
   );
endinterface

`default_nettype wire

// File: rtl/tsp_stim_checker.sv
// ============================================================================
// Module      : tsp_stim_checker
// Description : Seeded operand source and cycle-exact result checker for the
//               three-stage add/sub pipeline, with error statistics.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tsp_stim_checker #(
   parameter int DWIDTH      = 8,
   parameter int NUM_VECTORS = 16,
   parameter int CNT_W       = 16
) (
   input  wire logic          clk,
   input  wire logic          rst,
   tsp_stim_checker_if.master bus
);
   localparam int c_idx_w = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1;
   localparam int c_k_w   = $clog2(NUM_VECTORS + 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   typedef struct packed {
      logic                valid;
      logic [DWIDTH-1:0]   op1;
      logic [DWIDTH-1:0]   op2;
      logic [c_idx_w-1:0]  idx;
   } hist_t;

   state_t              r_state;
   hist_t               r_hist [4];
   logic [DWIDTH-1:0]   r_seed;
   logic [c_k_w-1:0]    r_k;
   logic                r_busy;
   logic                r_done;
   logic                r_pass;
   logic [CNT_W-1:0]    r_err;
   logic [c_idx_w-1:0]  r_first_idx;
   logic [DWIDTH-1:0]   r_first_exp;
   logic [DWIDTH-1:0]   r_first_got;

   logic [DWIDTH-1:0]   w_exp;
   logic                w_mismatch;
   logic [CNT_W-1:0]    w_err_nxt;
   logic [DWIDTH-1:0]   w_k_d;
   hist_t               w_vec;
   hist_t               w_start_vec;
   logic                w_drain_empty;

   // Entry 0 is the vector on the operand outputs right now; entry 3 is the
   // vector whose result is on res_i, and entry 2 holds its successor.
   assign w_exp      = r_hist[3].op1 + r_hist[3].op2 - r_hist[2].op1;
   assign w_mismatch = r_hist[3].valid && (bus.res_i != w_exp);
   assign w_err_nxt  = (w_mismatch && (r_err != {CNT_W{1'b1}})) ? r_err + CNT_W'(1) : r_err;

   assign w_k_d             = DWIDTH'(r_k);
   assign w_vec.valid       = 1'b1;
   assign w_vec.op1         = r_seed + w_k_d;
   assign w_vec.op2         = ~r_seed + (w_k_d << 1);
   assign w_vec.idx         = c_idx_w'(r_k);

   assign w_start_vec.valid = 1'b1;
   assign w_start_vec.op1   = bus.seed_i;
   assign w_start_vec.op2   = ~bus.seed_i;
   assign w_start_vec.idx   = '0;

   // Entry 3 is being compared on this edge, so only entries 0..2 matter.
   assign w_drain_empty = !r_hist[0].valid && !r_hist[1].valid && !r_hist[2].valid;

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_hist[0]   <= '0;
         r_hist[1]   <= '0;
         r_hist[2]   <= '0;
         r_hist[3]   <= '0;
         r_seed      <= '0;
         r_k         <= '0;
         r_busy      <= 1'b0;
         r_done      <= 1'b0;
         r_pass      <= 1'b0;
         r_err       <= '0;
         r_first_idx <= '0;
         r_first_exp <= '0;
         r_first_got <= '0;
      end else begin
         r_hist[0] <= '0;
         r_hist[1] <= r_hist[0];
         r_hist[2] <= r_hist[1];
         r_hist[3] <= r_hist[2];

         if (w_mismatch) begin
            r_err <= w_err_nxt;
            if (r_err == '0) begin
               r_first_idx <= r_hist[3].idx;
               r_first_exp <= w_exp;
               r_first_got <= bus.res_i;
            end
         end

         case (r_state)
            ST_IDLE, ST_DONE: begin
               if (bus.start_i) begin
                  r_state     <= ST_RUN;
                  r_seed      <= bus.seed_i;
                  r_k         <= c_k_w'(1);
                  r_hist[0]   <= w_start_vec;
                  r_busy      <= 1'b1;
                  r_done      <= 1'b0;
                  r_pass      <= 1'b0;
                  r_err       <= '0;
                  r_first_idx <= '0;
                  r_first_exp <= '0;
                  r_first_got <= '0;
               end
            end
            ST_RUN: begin
               if (r_k == c_k_w'(NUM_VECTORS)) begin
                  r_state <= ST_DRAIN;
               end else begin
                  r_hist[0] <= w_vec;
                  r_k       <= r_k + c_k_w'(1);
               end
            end
            ST_DRAIN: begin
               if (w_drain_empty) begin
                  r_state <= ST_DONE;
                  r_busy  <= 1'b0;
                  r_done  <= 1'b1;
                  r_pass  <= (w_err_nxt == '0);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   // Idle and drain cycles shift in all-zero entries, so these read 0 there.
   assign bus.op1_o           = r_hist[0].op1;
   assign bus.op2_o           = r_hist[0].op2;
   assign bus.busy_o          = r_busy;
   assign bus.done_o          = r_done;
   assign bus.pass_o          = r_pass;
   assign bus.err_cnt_o       = r_err;
   assign bus.first_err_idx_o = r_first_idx;
   assign bus.first_err_exp_o = r_first_exp;
   assign bus.first_err_got_o = r_first_got;

endmodule

`default_nettype wire

// File: doc/tsp_stim_checker.md
# tsp_stim_checker

Self-checking traffic source and sink for the three-stage add/sub pipeline (TSP). The block drives operand pairs into the pipeline's op1/op2 inputs and takes back its result, so it is the other end of that interface. It generates a deterministic vector sequence from a seed, models the pipeline's exact cycle behaviour, compares every returned result, and reports pass/fail with error statistics. It sits beside the TSP in the bring-up and regression top level.

## Interface
- DWIDTH, 8: operand and result width; must match the TSP.
- NUM_VECTORS, 16: vectors per run, at least 1.
- CNT_W, 16: width of the error counter; the counter saturates.
- clk  in  1  rising-edge clock, shared with the TSP.
- rst  in  1  synchronous, active-low reset; sampled on clk.
- start_i  in  1  level-sampled run request; honoured only in IDLE or DONE.
- seed_i  in  DWIDTH  sequence seed; captured when start is accepted.
- res_i  in  DWIDTH  TSP result (res_o).
- op1_o  out  DWIDTH  operand 1 to the TSP; registered.
- op2_o  out  DWIDTH  operand 2 to the TSP; registered.
- busy_o  out  1  high in RUN and DRAIN.
- done_o  out  1  high in DONE.
- pass_o  out  1  high in DONE when err_cnt_o == 0.
- err_cnt_o  out  CNT_W  number of mismatches; saturates at all-ones.
- first_err_idx_o  out  $clog2(NUM_VECTORS)  index of the first mismatching vector; valid when err_cnt_o != 0.
- first_err_exp_o / first_err_got_o  out  DWIDTH  expected and received values for the first mismatch.

## Operation
- Reset (rst == 0 at an edge): state IDLE. All outputs are 0, the history and valid pipe is cleared, and the vector index k is 0.
- Vector k, using all arithmetic mod 2^DWIDTH and the seed s captured at start:
  - op1(k) = s + k
  - op2(k) = ~s + 2k
- Outside RUN, op1_o and op2_o are 0.
- TSP model for vector k: exp(k) = op1(k) + op2(k) − op1(k+1).
  - op1(k+1) is the operand driven in the following cycle.
  - For the last vector, op1(k+1) = 0 because the block is draining.
- Internal state:
  - a 4-deep history shift register holding {valid, op1, op2, idx};
  - the expected value is formed from entry N and entry N−1's op1 at compare time.
- States:
  - IDLE: wait for start_i. On start go to RUN, capture seed_i, clear error state, and drive vector 0.
  - RUN: drive vector k each cycle. After driving vector NUM_VECTORS−1, go to DRAIN.
  - DRAIN: drive 0 and keep comparing until the valid pipe is empty, then go to DONE.
  - DONE: hold the results. start_i restarts exactly as from IDLE.
- start_i in RUN or DRAIN is ignored.
- Compare: only for valid history entries; res_i is ignored otherwise. On a mismatch:
  - increment err_cnt_o (saturating);
  - if this is the first mismatch, latch first_err_idx_o, first_err_exp_o and first_err_got_o.
- Reset mid-run aborts immediately: state IDLE, operands 0, statistics cleared.

## Timing
- E0 is the edge that accepts start. Vector k appears on op1_o/op2_o after edge E_k and the TSP captures it at E_{k+1}.
- The TSP result for vector k is present after E_{k+3}. The checker samples res_i at E_{k+4}.
- Last compare is at E_{NUM_VECTORS+3}:
  - done_o and pass_o rise after that edge;
  - err_cnt_o already includes that compare.
- busy_o is high from after E0 through the cycle before done_o.
- Run length is NUM_VECTORS+4 cycles from start to done_o.
- Back-to-back run: start_i held high in DONE restarts at the next edge. done_o falls and busy_o rises in the same cycle.
- Error outputs are stable from the compare edge until the next start or reset.

## Test plan
- Clean run: DWIDTH=8, NUM_VECTORS=4, seed 0x10.
  - Ops go 10/EF, 11/F1, 12/F3, 13/F5, then 0.
  - Expected results are EE, F0, F2, 08.
  - done_o after E7, pass_o=1, err_cnt_o=0.
- Injected fault: same run, but force res_i to 0x00 at E6 (vector 2).
  - err_cnt_o=1, first_err_idx_o=2, exp=F2, got=00, pass_o=0.
- Wrap-around: seed 0xFF, NUM_VECTORS=3.
  - op1 sequence is FF, 00, 01; op2 is 00, 02, 04.
  - Expected results are FF, 01, 05.
  - Pass against a real TSP.
- Reset mid-run: rst low at E2 of a run.
  - Next cycle: IDLE, all outputs 0.
  - New start with seed 0x10 reproduces the clean-run results.
- start_i held high for the whole run:
  - no restart during RUN or DRAIN;
  - restart at the first edge in DONE, with done_o low for exactly the new run.
- Saturation: CNT_W=2, NUM_VECTORS=8, res_i tied to 0x00 with seed 0x10.
  - err_cnt_o stops at 3; first_err_idx_o=0, exp=EE, got=00.
